nanorv32_intc: RTL and testbench

Interrupt controller in front of the core's single irq input. Collects NUM_IRQ external sources, latches edge-type requests, and applies enable masking and fixed priority (index 0 highest). Presents one request with its ID to the pipeline flow controller, then holds off further requests until the core signals that the interrupt-exit sequence has completed. Configured through a small register port on the core's data bus decode.

---
 rtl/nanorv32_intc.sv | 173 +++++++++++++++++
 tb/tb_nanorv32_intc.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nanorv32_intc.sv
// rtl/nanorv32_intc.sv - fixed-priority interrupt controller in front of the nanorv32 irq input
//
// Build option: define NANORV32_INTC_SYNC_EN to place a 2-flop synchronizer on irq_src
// (irq_src asynchronous to clk). Leave it undefined when irq_src is already synchronous.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   irq_src             raw interrupt sources
//   reg_sel/reg_wr/
//   reg_wdata/reg_rdata register port: 0 ENABLE, 1 PENDING (W1C), 2 EDGE_SEL, 3 STATUS (RO)
//   irq, irq_id         request and source ID presented to the flow controller
//   irq_ack             core entered the interrupt-entry sequence
//   reti_done           core completed the interrupt-exit sequence
//   in_service          an interrupt is being serviced
module nanorv32_intc #(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_src,
  input  logic [1:0]         reg_sel,
  input  logic               reg_wr,
  input  logic [31:0]        reg_wdata,
  output logic [31:0]        reg_rdata,
  output logic               irq,
  input  logic               irq_ack,
  output logic [ID_W-1:0]    irq_id,
  input  logic               reti_done,
  output logic               in_service
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  localparam logic [1:0] RS_ENABLE   = 2'd0;
  localparam logic [1:0] RS_PENDING  = 2'd1;
  localparam logic [1:0] RS_EDGE_SEL = 2'd2;
  localparam logic [1:0] RS_STATUS   = 2'd3;

  logic [1:0]         state;
  logic [NUM_IRQ-1:0] src_q;       // source as seen by the edge detector and level path
  logic [NUM_IRQ-1:0] s3;
  logic [NUM_IRQ-1:0] edge_q;      // registered rising-edge pulse
  logic [NUM_IRQ-1:0] pend_edge;   // latched edge requests
  logic [NUM_IRQ-1:0] enable_r;
  logic [NUM_IRQ-1:0] edge_sel_r;
  logic [NUM_IRQ-1:0] pend;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] w1c_mask;
  logic [NUM_IRQ-1:0] ack_mask;
  logic [ID_W-1:0]    sel;
  logic               ack_take;
  logic               wdata_unused;

  // Only the low NUM_IRQ write-data bits carry register content.
  assign wdata_unused = ^reg_wdata;

`ifdef NANORV32_INTC_SYNC_EN
  logic [NUM_IRQ-1:0] s1;
  logic [NUM_IRQ-1:0] s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= irq_src;
      s2 <= s1;
    end
  end

  assign src_q = s2;
`else
  assign src_q = irq_src;
`endif

  // The rising-edge pulse is registered before it sets pend, keeping the
  // pend set path free of the synchronizer-to-priority-encoder chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3     <= '0;
      edge_q <= '0;
    end else begin
      s3     <= src_q;
      edge_q <= src_q & ~s3;
    end
  end

  // Level sources are not stored: they follow the synchronized input.
  assign pend     = (pend_edge & edge_sel_r) | (src_q & ~edge_sel_r);
  assign eligible = pend & enable_r;

  always_comb begin
    sel = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) sel = ID_W'(i);
    end
  end

  assign ack_take = (state == ST_REQ) && irq_ack;
  assign ack_mask = ack_take ? ({{(NUM_IRQ-1){1'b0}}, 1'b1} << irq_id) : '0;
  assign w1c_mask = (reg_wr && reg_sel == RS_PENDING) ? reg_wdata[NUM_IRQ-1:0] : '0;

  // Set wins over clear; masking with edge_sel_r drops stale bits when a
  // source is switched to level mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_edge <= '0;
    end else begin
      pend_edge <= ((pend_edge & ~(w1c_mask | ack_mask)) | edge_q) & edge_sel_r;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_r   <= '0;
      edge_sel_r <= '0;
    end else if (reg_wr) begin
      if (reg_sel == RS_ENABLE)   enable_r   <= reg_wdata[NUM_IRQ-1:0];
      if (reg_sel == RS_EDGE_SEL) edge_sel_r <= reg_wdata[NUM_IRQ-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      irq_id <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|eligible) begin
            state  <= ST_REQ;
            irq_id <= sel;
          end
        end
        ST_REQ: begin
          // Ack freezes the ID presented this cycle and beats a simultaneous withdraw.
          if (irq_ack) begin
            state <= ST_SERVICE;
          end else if (!(|eligible)) begin
            state <= ST_IDLE;
          end else begin
            irq_id <= sel;
          end
        end
        ST_SERVICE: begin
          if (reti_done) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign irq        = (state == ST_REQ);
  assign in_service = (state == ST_SERVICE);

  always_comb begin
    reg_rdata = '0;
    case (reg_sel)
      RS_ENABLE:   reg_rdata = 32'(enable_r);
      RS_PENDING:  reg_rdata = 32'(pend);
      RS_EDGE_SEL: reg_rdata = 32'(edge_sel_r);
      RS_STATUS: begin
        reg_rdata[31]       = in_service;
        reg_rdata[ID_W-1:0] = irq_id;
      end
      default:     reg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_nanorv32_intc.sv
// tb/tb_nanorv32_intc.sv - self-checking bench for nanorv32_intc
module tb_nanorv32_intc;

  localparam int NUM_IRQ = 8;
  localparam int ID_W    = 3;
`ifdef NANORV32_INTC_SYNC_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic [NUM_IRQ-1:0] irq_src = '0;
  logic [1:0]         reg_sel = '0;
  logic               reg_wr = 1'b0;
  logic [31:0]        reg_wdata = '0;
  logic [31:0]        reg_rdata;
  logic               irq;
  logic               irq_ack = 1'b0;
  logic [ID_W-1:0]    irq_id;
  logic               reti_done = 1'b0;
  logic               in_service;

  nanorv32_intc #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .irq_src    (irq_src),
    .reg_sel    (reg_sel),
    .reg_wr     (reg_wr),
    .reg_wdata  (reg_wdata),
    .reg_rdata  (reg_rdata),
    .irq        (irq),
    .irq_ack    (irq_ack),
    .irq_id     (irq_id),
    .reti_done  (reti_done),
    .in_service (in_service)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      $error("FAIL sb_empty observed=%h expected=none", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] s, input logic [31:0] d);
    reg_sel   = s;
    reg_wdata = d;
    reg_wr    = 1'b1;
    tick();
    reg_wr    = 1'b0;
  endtask

  task automatic rd_chk(input logic [1:0] s, input string tag, input logic [31:0] exp);
    push(tag, exp);
    reg_sel = s;
    #1;
    check(reg_rdata);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset
    #2 rst_n = 1'b0;
    tick();
    tick();
    push("rst_irq", 0);        check(32'(irq));
    push("rst_id", 0);         check(32'(irq_id));
    push("rst_insvc", 0);      check(32'(in_service));
    rd_chk(2'd0, "rst_enable", 32'h0);
    rd_chk(2'd1, "rst_pending", 32'h0);
    rd_chk(2'd2, "rst_edge_sel", 32'h0);
    tick();
    rd_chk(2'd3, "rst_status", 32'h0);
    rst_n = 1'b1;
    tick();

    // Edge source 0: one-cycle pulse, latency, ack, reti
    wr(2'd0, 32'h01);
    wr(2'd2, 32'h01);
    irq_src[0] = 1'b1;
    for (int k = 1; k <= LAT; k++) push($sformatf("s1_irq_edge%0d", k), 32'(k == LAT));
    for (int k = 1; k <= LAT; k++) begin
      tick();
      if (k == 1) irq_src[0] = 1'b0;
      check(32'(irq));
    end
    push("s1_id", 0);          check(32'(irq_id));
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    push("s1_ack_irq", 0);     check(32'(irq));
    push("s1_ack_insvc", 1);   check(32'(in_service));
    rd_chk(2'd1, "s1_pending", 32'h0);
    rd_chk(2'd3, "s1_status", 32'h8000_0000);
    reti_done = 1'b1; tick(); reti_done = 1'b0;
    push("s1_reti_insvc", 0);  check(32'(in_service));
    push("s1_reti_irq", 0);    check(32'(irq));
    tick();
    push("s1_no_rereq", 0);    check(32'(irq));

    // Higher-priority arrival before ack replaces the ID
    wr(2'd0, 32'hFF);
    wr(2'd2, 32'hFF);
    irq_src[5] = 1'b1;
    tick(); tick();
    irq_src[2] = 1'b1;
    repeat (LAT - 2) tick();
    push("s2_irq", 1);         check(32'(irq));
    push("s2_id5", 5);         check(32'(irq_id));
    tick(); tick();
    push("s2_id2", 2);         check(32'(irq_id));
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    push("s2_insvc", 1);       check(32'(in_service));
    rd_chk(2'd3, "s2_status", 32'h8000_0002);
    rd_chk(2'd1, "s2_pending", 32'h20);
    reti_done = 1'b1; tick(); reti_done = 1'b0;
    push("s2_bubble", 0);      check(32'(irq));
    tick();
    push("s2_rereq", 1);       check(32'(irq));
    push("s2_rereq_id", 5);    check(32'(irq_id));
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    reti_done = 1'b1; tick(); reti_done = 1'b0;
    irq_src = '0;

    // Level source 3: W1C ignored, drop withdraws request
    wr(2'd2, 32'h00);
    wr(2'd0, 32'h08);
    irq_src[3] = 1'b1;
    repeat (LAT - 2) tick();
    push("s3_irq", 1);         check(32'(irq));
    push("s3_id", 3);          check(32'(irq_id));
    wr(2'd1, 32'h08);
    rd_chk(2'd1, "s3_w1c_ignored", 32'h08);
    irq_src[3] = 1'b0;
    repeat (LAT - 2) tick();
    push("s3_withdraw", 0);    check(32'(irq));
    push("s3_status_insvc", 0);
    reg_sel = 2'd3; #1;
    check(32'(reg_rdata[31]));

    // Edge source 1: W1C and a new edge in the same cycle, set wins
    wr(2'd0, 32'h00);
    wr(2'd2, 32'h02);
    irq_src[1] = 1'b1;
    for (int k = 1; k <= LAT - 1; k++) begin
      tick();
      if (k == 1) irq_src[1] = 1'b0;
    end
    rd_chk(2'd1, "s4_pend_set", 32'h02);
    wr(2'd1, 32'h02);
    rd_chk(2'd1, "s4_w1c", 32'h00);
    irq_src[1] = 1'b1;
    for (int k = 1; k <= LAT - 2; k++) begin
      tick();
      if (k == 1) irq_src[1] = 1'b0;
    end
    wr(2'd1, 32'h02);
    rd_chk(2'd1, "s4_set_wins", 32'h02);
    push("s4_masked_irq", 0);  check(32'(irq));
    wr(2'd1, 32'h02);
    wr(2'd2, 32'h00);

    // Ack together with withdraw; spurious ack and reti
    wr(2'd0, 32'h10);
    irq_src[4] = 1'b1;
    repeat (LAT - 2) tick();
    push("s5_irq", 1);         check(32'(irq));
    irq_src[4] = 1'b0;
    repeat (LAT - 3) tick();
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    push("s5_ack_wins", 1);    check(32'(in_service));
    push("s5_ack_id", 4);      check(32'(irq_id));
    reti_done = 1'b1; tick(); reti_done = 1'b0;
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    push("s5_idle_ack_svc", 0); check(32'(in_service));
    push("s5_idle_ack_irq", 0); check(32'(irq));
    irq_src[4] = 1'b1;
    repeat (LAT - 2) tick();
    reti_done = 1'b1; tick(); reti_done = 1'b0;
    push("s5_req_reti_irq", 1); check(32'(irq));
    push("s5_req_reti_svc", 0); check(32'(in_service));
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    irq_src[4] = 1'b0;
    reti_done = 1'b1; tick(); reti_done = 1'b0;

    // Reset during service with pending 0x30
    wr(2'd0, 32'hFF);
    wr(2'd2, 32'hFF);
    irq_src = 8'h31;
    tick();
    irq_src = '0;
    repeat (LAT - 1) tick();
    push("s6_irq", 1);         check(32'(irq));
    push("s6_id", 0);          check(32'(irq_id));
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    push("s6_insvc", 1);       check(32'(in_service));
    rd_chk(2'd1, "s6_pending", 32'h30);
    rst_n = 1'b0;
    #1;
    push("s6_rst_irq", 0);     check(32'(irq));
    push("s6_rst_insvc", 0);   check(32'(in_service));
    tick();
    rst_n = 1'b1;
    rd_chk(2'd1, "s6_rst_pending", 32'h0);
    rd_chk(2'd0, "s6_rst_enable", 32'h0);
    rd_chk(2'd3, "s6_rst_status", 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
